// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one LSRAM port between requester A (bus bridge) and B (test engine),
// with a pipelined read-owner tag. Define SRAM_ARB_STATS_EN to add grant/conflict statistics counters.
module sram_port_arbiter #(
   parameter int AW     = 10,
   parameter int DW     = 20,
   parameter int RD_LAT = 2,
   parameter int CNT_W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          sram_wen,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata
`ifdef SRAM_ARB_STATS_EN
   ,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_a_cnt,
   output logic [CNT_W-1:0] stat_b_cnt,
   output logic [CNT_W-1:0] stat_conf_cnt
`endif
);

   typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

   owner_e          last_q, last_d;
   logic            gnt_a, gnt_b;
   logic            wen_q, wen_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [RD_LAT:0] tag_vld_q, tag_vld_d;
   logic [RD_LAT:0] tag_own_q, tag_own_d;

   always_comb begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      last_d  = last_q;
      wen_d   = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (!rst) begin
         if (a_req && (!b_req || last_q == OWN_B)) begin
            gnt_a = 1'b1;
         end else if (b_req) begin
            gnt_b = 1'b1;
         end
      end
      if (gnt_a) begin
         last_d  = OWN_A;
         wen_d   = a_we;
         addr_d  = a_addr;
         wdata_d = a_wdata;
      end else if (gnt_b) begin
         last_d  = OWN_B;
         wen_d   = b_we;
         addr_d  = b_addr;
         wdata_d = b_wdata;
      end
      // Tag stage k is live in cycle N+1+k; the last stage lines up with RAM read data.
      tag_vld_d = {tag_vld_q[RD_LAT-1:0], (gnt_a & ~a_we) | (gnt_b & ~b_we)};
      tag_own_d = {tag_own_q[RD_LAT-1:0], gnt_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q    <= OWN_B;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tag_vld_q <= '0;
         tag_own_q <= '0;
      end else begin
         last_q    <= last_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tag_vld_q <= tag_vld_d;
         tag_own_q <= tag_own_d;
      end
   end

   assign a_gnt      = gnt_a;
   assign b_gnt      = gnt_b;
   assign sram_wen   = wen_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   // Returns are suppressed while reset is held so discarded reads never surface.
   assign a_rvalid   = ~rst & tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
   assign b_rvalid   = ~rst & tag_vld_q[RD_LAT] &  tag_own_q[RD_LAT];
   assign a_rdata    = sram_rdata;
   assign b_rdata    = sram_rdata;

`ifdef SRAM_ARB_STATS_EN
   logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
   logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
   logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      a_cnt_d    = sat_inc(a_cnt_q, gnt_a);
      b_cnt_d    = sat_inc(b_cnt_q, gnt_b);
      conf_cnt_d = sat_inc(conf_cnt_q, a_req & b_req);
   end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         a_cnt_q    <= '0;
         b_cnt_q    <= '0;
         conf_cnt_q <= '0;
      end else begin
         a_cnt_q    <= a_cnt_d;
         b_cnt_q    <= b_cnt_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   assign stat_a_cnt    = a_cnt_q;
   assign stat_b_cnt    = b_cnt_q;
   assign stat_conf_cnt = conf_cnt_q;
`endif

endmodule
